// File: rtl/hazard_forward_unit_pkg.sv
// Shared types for the decode-stage hazard/forwarding unit.
package hazard_forward_unit_pkg;

  // Architectural register index width; x0 is hard-wired zero and never matches.
  localparam int unsigned REG_ADDR_W = 5;
  // Stage-number width inside track entries; covers FWD_DEPTH up to 15.
  localparam int unsigned STAGE_W    = 4;

  typedef logic [STAGE_W-1:0] fwd_stage_t;

  // Operand taken from the register file rather than a downstream stage.
  localparam fwd_stage_t FWD_SRC_RF = '0;

  // One in-flight instruction downstream of decode.
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    fwd_stage_t            ready_stage;
  } track_entry_t;

endpackage

// File: rtl/hazard_forward_unit_if.sv
// Decode-side bus of the hazard/forwarding unit; parameters must match the unit.
interface hazard_forward_unit_if
  import hazard_forward_unit_pkg::*;
#(
  parameter int unsigned XLEN      = 64,
  parameter int unsigned NUM_SRC   = 2,
  parameter int unsigned FWD_DEPTH = 2,
  parameter int unsigned CNT_W     = 32
) ();

  localparam int unsigned SW = $clog2(FWD_DEPTH + 1);

  logic                          id_valid;
  logic [REG_ADDR_W-1:0]         id_rd;
  logic                          id_reg_write;
  logic                          id_is_load;
  logic [NUM_SRC*REG_ADDR_W-1:0] id_rs;
  logic [NUM_SRC-1:0]            id_rs_used;
  logic [NUM_SRC*XLEN-1:0]       id_rf_data;
  logic [FWD_DEPTH*XLEN-1:0]     stage_result;
  logic                          flush;
  logic [NUM_SRC*XLEN-1:0]       fwd_data;
  logic [NUM_SRC*SW-1:0]         fwd_stage;
  logic                          f_to_d_enable_ff;
  logic                          d_to_e_enable_ff;
  logic                          id_bubble;
  logic [CNT_W-1:0]              stall_cycles;

  // Pipeline/decode side.
  modport master (
    output id_valid, id_rd, id_reg_write, id_is_load, id_rs, id_rs_used,
           id_rf_data, stage_result, flush,
    input  fwd_data, fwd_stage, f_to_d_enable_ff, d_to_e_enable_ff,
           id_bubble, stall_cycles
  );

  // Hazard unit side.
  modport slave (
    input  id_valid, id_rd, id_reg_write, id_is_load, id_rs, id_rs_used,
           id_rf_data, stage_result, flush,
    output fwd_data, fwd_stage, f_to_d_enable_ff, d_to_e_enable_ff,
           id_bubble, stall_cycles
  );

endinterface

// File: rtl/hazard_forward_unit_src_match.sv
// Per-source operand resolution: youngest matching producer wins, stalls if not ready.
module hfu_src_match
  import hazard_forward_unit_pkg::*;
#(
  parameter int unsigned XLEN      = 64,
  parameter int unsigned FWD_DEPTH = 2
) (
  input  logic [REG_ADDR_W-1:0]         rs_i,
  input  logic                          used_i,
  input  track_entry_t [FWD_DEPTH:1]    trk_i,
  input  logic [FWD_DEPTH*XLEN-1:0]     stage_result_i,
  input  logic [XLEN-1:0]               rf_data_i,
  output logic [XLEN-1:0]               data_c,
  output fwd_stage_t                    stage_c,
  output logic                          hazard_c
);

  logic            found;
  fwd_stage_t      win_stage;
  fwd_stage_t      win_ready;
  logic [XLEN-1:0] win_data;

  // Find youngest producer; older matches are shadowed even if they are ready.
  always_comb begin
    found     = 1'b0;
    win_stage = FWD_SRC_RF;
    win_ready = '0;
    win_data  = '0;
    for (int s = 1; s <= FWD_DEPTH; s++) begin
      if (!found && trk_i[s].valid && trk_i[s].reg_write && used_i &&
          (rs_i != '0) && (trk_i[s].rd == rs_i)) begin
        found     = 1'b1;
        win_stage = fwd_stage_t'(s);
        win_ready = trk_i[s].ready_stage;
        win_data  = stage_result_i[(s-1)*XLEN +: XLEN];
      end
    end
  end

  // Forward when the winner has produced its result, otherwise flag a hazard.
  always_comb begin
    data_c   = rf_data_i;
    stage_c  = FWD_SRC_RF;
    hazard_c = 1'b0;
    if (found) begin
      if (win_stage >= win_ready) begin
        data_c  = win_data;
        stage_c = win_stage;
      end else begin
        hazard_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Decode-stage hazard detection and operand forwarding with stall counter.
module hazard_forward_unit
  import hazard_forward_unit_pkg::*;
#(
  parameter int unsigned XLEN         = 64,
  parameter int unsigned NUM_SRC      = 2,
  parameter int unsigned FWD_DEPTH    = 2,
  parameter int unsigned LOAD_LATENCY = 1,
  parameter int unsigned CNT_W        = 32
) (
  input  logic                clk,
  input  logic                rst,
  hazard_forward_unit_if.slave bus
);

  localparam int unsigned SW = $clog2(FWD_DEPTH + 1);
  localparam fwd_stage_t  READY_LOAD  = fwd_stage_t'(1 + LOAD_LATENCY);
  localparam fwd_stage_t  READY_ALU   = fwd_stage_t'(1);

  track_entry_t [FWD_DEPTH:1] trk_q, trk_d;
  logic [CNT_W-1:0]           stall_cnt_q, stall_cnt_d;
  logic [NUM_SRC-1:0]         hazard_c;
  fwd_stage_t [NUM_SRC-1:0]   src_stage_c;
  logic [NUM_SRC*XLEN-1:0]    fwd_data_c;
  logic [NUM_SRC*SW-1:0]      fwd_stage_c;
  logic                       stall_c;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    hfu_src_match #(
      .XLEN      (XLEN),
      .FWD_DEPTH (FWD_DEPTH)
    ) u_match (
      .rs_i           (bus.id_rs[k*REG_ADDR_W +: REG_ADDR_W]),
      .used_i         (bus.id_rs_used[k]),
      .trk_i          (trk_q),
      .stage_result_i (bus.stage_result),
      .rf_data_i      (bus.id_rf_data[k*XLEN +: XLEN]),
      .data_c         (fwd_data_c[k*XLEN +: XLEN]),
      .stage_c        (src_stage_c[k]),
      .hazard_c       (hazard_c[k])
    );
  end

  // Any unresolved source holds fetch/decode; a redirect overrides the stall.
  assign stall_c = bus.id_valid & (|hazard_c) & ~bus.flush;

  // Narrow internal stage numbers to the port width.
  always_comb begin
    fwd_stage_c = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      fwd_stage_c[k*SW +: SW] = SW'(src_stage_c[k]);
    end
  end

  // Next tracking state: decode enters stage 1, everything else advances.
  always_comb begin
    trk_d             = '0;
    trk_d[1].valid    = bus.id_valid & ~stall_c & ~bus.flush;
    trk_d[1].rd       = bus.id_rd;
    trk_d[1].reg_write = bus.id_reg_write;
    trk_d[1].ready_stage = bus.id_is_load ? READY_LOAD : READY_ALU;
    for (int s = 2; s <= FWD_DEPTH; s++) begin
      trk_d[s] = trk_q[s-1];
    end
  end

  // Saturating stall counter.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_c && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // State registers; reset clears the tracker so enables recover immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trk_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      trk_q       <= trk_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.fwd_data         = fwd_data_c;
  assign bus.fwd_stage        = fwd_stage_c;
  assign bus.f_to_d_enable_ff = ~stall_c;
  assign bus.d_to_e_enable_ff = 1'b1;
  assign bus.id_bubble        = stall_c | bus.flush;
  assign bus.stall_cycles     = stall_cnt_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit: default config plus a deep 3-source config.
module tb_hazard_forward_unit;

  logic clk = 1'b0;
  logic rst;
  logic rst_b;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  hazard_forward_unit_if #(.XLEN(64), .NUM_SRC(2), .FWD_DEPTH(2), .CNT_W(32)) ifa ();
  hazard_forward_unit_if #(.XLEN(16), .NUM_SRC(3), .FWD_DEPTH(3), .CNT_W(2))  ifb ();

  hazard_forward_unit #(
    .XLEN(64), .NUM_SRC(2), .FWD_DEPTH(2), .LOAD_LATENCY(1), .CNT_W(32)
  ) u_dut_a (.clk(clk), .rst(rst), .bus(ifa));

  hazard_forward_unit #(
    .XLEN(16), .NUM_SRC(3), .FWD_DEPTH(3), .LOAD_LATENCY(2), .CNT_W(2)
  ) u_dut_b (.clk(clk), .rst(rst_b), .bus(ifb));

  localparam logic [63:0] SR1 = 64'h1111_0000_0000_0001;
  localparam logic [63:0] SR2 = 64'h2222_0000_0000_0002;
  localparam logic [63:0] RF0 = 64'hA0A0_A0A0_A0A0_A0A0;
  localparam logic [63:0] RF1 = 64'hB0B0_B0B0_B0B0_B0B0;
  localparam logic [15:0] BS1 = 16'h0101;
  localparam logic [15:0] BS2 = 16'h0202;
  localparam logic [15:0] BS3 = 16'h0303;
  localparam logic [15:0] BR0 = 16'h0A0A;
  localparam logic [15:0] BR1 = 16'h0B0B;
  localparam logic [15:0] BR2 = 16'h0C0C;

  typedef struct {
    logic       vld;
    logic [4:0] rd;
    logic       rw;
    logic       ld;
    logic [4:0] rs0;
    logic [4:0] rs1;
    logic [1:0] used;
    logic       flush;
    int         st0;
    int         st1;
    logic       stall;
    logic       bub;
    int         cnt;
  } vec_t;

  localparam int NV = 17;
  vec_t vt [NV];

  function automatic vec_t mk(logic vld, logic [4:0] rd, logic rw, logic ld,
                              logic [4:0] rs0, logic [4:0] rs1, logic [1:0] used,
                              logic flush, int st0, int st1, logic stall,
                              logic bub, int cnt);
    vec_t v;
    v.vld = vld; v.rd = rd; v.rw = rw; v.ld = ld; v.rs0 = rs0; v.rs1 = rs1;
    v.used = used; v.flush = flush; v.st0 = st0; v.st1 = st1;
    v.stall = stall; v.bub = bub; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] exp_a(int k, int st);
    if (st == 1) return SR1;
    if (st == 2) return SR2;
    return (k == 0) ? RF0 : RF1;
  endfunction

  function automatic logic [15:0] exp_b(int k, int st);
    if (st == 1) return BS1;
    if (st == 2) return BS2;
    if (st == 3) return BS3;
    if (k == 0) return BR0;
    if (k == 1) return BR1;
    return BR2;
  endfunction

  task automatic drvb(logic vld, logic [4:0] rd, logic rw, logic ld,
                      logic [4:0] rs0, logic [4:0] rs1, logic [4:0] rs2, logic [2:0] used);
    ifb.id_valid     = vld;
    ifb.id_rd        = rd;
    ifb.id_reg_write = rw;
    ifb.id_is_load   = ld;
    ifb.id_rs        = {rs2, rs1, rs0};
    ifb.id_rs_used   = used;
  endtask

  task automatic chkb(string nm, logic en, logic bub, int st, int cnt);
    logic [5:0]  stg;
    logic [47:0] dat;
    stg = ifb.fwd_stage;
    dat = ifb.fwd_data;
    chk({nm, ".f_to_d"}, 64'(ifb.f_to_d_enable_ff), 64'(en));
    chk({nm, ".bubble"}, 64'(ifb.id_bubble), 64'(bub));
    chk({nm, ".cnt"}, 64'(ifb.stall_cycles), 64'(cnt));
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s.stage%0d", nm, k), 64'(stg[k*2 +: 2]), 64'(st));
      chk($sformatf("%s.data%0d", nm, k), 64'(dat[k*16 +: 16]), 64'(exp_b(k, st)));
    end
  endtask

  initial begin
    logic [3:0]   stga;
    logic [127:0] data;

    rst = 1'b1;
    rst_b = 1'b1;
    ifa.id_valid = 1'b0; ifa.id_rd = '0; ifa.id_reg_write = 1'b0; ifa.id_is_load = 1'b0;
    ifa.id_rs = '0; ifa.id_rs_used = '0; ifa.flush = 1'b0;
    ifa.id_rf_data = {RF1, RF0};
    ifa.stage_result = {SR2, SR1};
    drvb(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 3'b000);
    ifb.flush = 1'b0;
    ifb.id_rf_data = {BR2, BR1, BR0};
    ifb.stage_result = {BS3, BS2, BS1};

    //       vld rd  rw ld  rs0 rs1 used  fl  st0 st1 stall bub cnt
    vt[0]  = mk(0, 0,  0, 0, 0,  0,  2'b00, 0, 0, 0, 0, 0, 0);
    vt[1]  = mk(1, 5,  1, 0, 1,  2,  2'b11, 0, 0, 0, 0, 0, 0);
    vt[2]  = mk(1, 6,  1, 0, 5,  7,  2'b11, 0, 1, 0, 0, 0, 0);
    vt[3]  = mk(1, 5,  1, 1, 0,  0,  2'b00, 0, 0, 0, 0, 0, 0);
    vt[4]  = mk(1, 6,  1, 0, 5,  5,  2'b11, 0, 0, 0, 1, 1, 0);
    vt[5]  = mk(1, 6,  1, 0, 5,  5,  2'b11, 0, 2, 2, 0, 0, 1);
    vt[6]  = mk(1, 5,  1, 0, 0,  0,  2'b00, 0, 0, 0, 0, 0, 1);
    vt[7]  = mk(1, 5,  1, 0, 6,  0,  2'b01, 0, 2, 0, 0, 0, 1);
    vt[8]  = mk(1, 0,  1, 0, 5,  5,  2'b11, 0, 1, 1, 0, 0, 1);
    vt[9]  = mk(1, 8,  1, 1, 0,  0,  2'b11, 0, 0, 0, 0, 0, 1);
    vt[10] = mk(1, 9,  1, 0, 8,  8,  2'b00, 0, 0, 0, 0, 0, 1);
    vt[11] = mk(1, 0,  0, 0, 8,  0,  2'b01, 0, 2, 0, 0, 0, 1);
    vt[12] = mk(1, 10, 1, 1, 0,  0,  2'b00, 0, 0, 0, 0, 0, 1);
    vt[13] = mk(1, 11, 1, 0, 10, 0,  2'b01, 1, 0, 0, 0, 1, 1);
    vt[14] = mk(0, 0,  0, 0, 11, 10, 2'b11, 0, 0, 2, 0, 0, 1);
    vt[15] = mk(1, 12, 1, 1, 0,  0,  2'b00, 0, 0, 0, 0, 0, 1);
    vt[16] = mk(0, 0,  0, 0, 12, 0,  2'b01, 0, 0, 0, 0, 0, 1);

    // Reset state of both instances.
    tick();
    tick();
    chk("rst.a.f_to_d", 64'(ifa.f_to_d_enable_ff), 64'd1);
    chk("rst.a.bubble", 64'(ifa.id_bubble), 64'd0);
    chk("rst.a.cnt", 64'(ifa.stall_cycles), 64'd0);
    chk("rst.a.data", 64'(ifa.fwd_data[63:0]), RF0);
    chkb("rst.b", 1'b1, 1'b0, 0, 0);
    rst = 1'b0;
    rst_b = 1'b0;

    // Table-driven sequence on the default configuration.
    for (int i = 0; i < NV; i++) begin
      tick();
      ifa.id_valid     = vt[i].vld;
      ifa.id_rd        = vt[i].rd;
      ifa.id_reg_write = vt[i].rw;
      ifa.id_is_load   = vt[i].ld;
      ifa.id_rs        = {vt[i].rs1, vt[i].rs0};
      ifa.id_rs_used   = vt[i].used;
      ifa.flush        = vt[i].flush;
      #4;
      stga = ifa.fwd_stage;
      data = ifa.fwd_data;
      chk($sformatf("v%0d.stage0", i), 64'(stga[1:0]), 64'(vt[i].st0));
      chk($sformatf("v%0d.stage1", i), 64'(stga[3:2]), 64'(vt[i].st1));
      chk($sformatf("v%0d.data0", i), data[63:0], exp_a(0, vt[i].st0));
      chk($sformatf("v%0d.data1", i), data[127:64], exp_a(1, vt[i].st1));
      chk($sformatf("v%0d.f_to_d", i), 64'(ifa.f_to_d_enable_ff), 64'(!vt[i].stall));
      chk($sformatf("v%0d.d_to_e", i), 64'(ifa.d_to_e_enable_ff), 64'd1);
      chk($sformatf("v%0d.bubble", i), 64'(ifa.id_bubble), 64'(vt[i].bub));
      chk($sformatf("v%0d.cnt", i), 64'(ifa.stall_cycles), 64'(vt[i].cnt));
    end

    // Deep config: load x5 then 3-source consumer -> two stall cycles, then stage 3.
    tick(); drvb(1'b1, 5'd5, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 3'b000); #4;
    chkb("b.ld5", 1'b1, 1'b0, 0, 0);
    tick(); drvb(1'b1, 5'd6, 1'b1, 1'b0, 5'd5, 5'd5, 5'd5, 3'b111); #4;
    chkb("b.use5.c1", 1'b0, 1'b1, 0, 0);
    tick(); #4;
    chkb("b.use5.c2", 1'b0, 1'b1, 0, 1);
    tick(); #4;
    chkb("b.use5.fwd", 1'b1, 1'b0, 3, 2);

    // Counter saturation at 3 across a second load-use stall.
    tick(); drvb(1'b1, 5'd7, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 3'b000); #4;
    chk("b.ld7.f_to_d", 64'(ifb.f_to_d_enable_ff), 64'd1);
    tick(); drvb(1'b1, 5'd8, 1'b1, 1'b0, 5'd7, 5'd0, 5'd0, 3'b001); #4;
    chk("b.use7.c1.f_to_d", 64'(ifb.f_to_d_enable_ff), 64'd0);
    chk("b.use7.c1.cnt", 64'(ifb.stall_cycles), 64'd2);
    tick(); #4;
    chk("b.use7.c2.f_to_d", 64'(ifb.f_to_d_enable_ff), 64'd0);
    chk("b.use7.c2.cnt", 64'(ifb.stall_cycles), 64'd3);
    tick(); #4;
    chk("b.use7.fwd.f_to_d", 64'(ifb.f_to_d_enable_ff), 64'd1);
    chk("b.use7.fwd.stage0", 64'(ifb.fwd_stage[1:0]), 64'd3);
    chk("b.sat.cnt", 64'(ifb.stall_cycles), 64'd3);

    // Reset asserted in the middle of a stall releases the enables immediately.
    tick(); drvb(1'b1, 5'd9, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 3'b000); #4;
    tick(); drvb(1'b1, 5'd10, 1'b1, 1'b0, 5'd0, 5'd9, 5'd0, 3'b010); #4;
    chk("b.use9.f_to_d", 64'(ifb.f_to_d_enable_ff), 64'd0);
    rst_b = 1'b1;
    #1;
    chkb("b.midrst", 1'b1, 1'b0, 0, 0);
    tick();
    rst_b = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
